reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-read-port integer register file for the ID stage; successor to the fixed 2-read, 32x32 register file.
- Synchronous write on clk with write-first bypass to every read port.
- On synchronous reset it runs a hardware sweep that loads every register with its init value, one register per cycle.
- Holds a per-register pending (scoreboard) bit so ID can detect reads of registers whose writeback is still outstanding.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (≥2); register 0 is hardwired to 0.
- NRD, 2, number of read ports (≥1).
- INIT_MODE, 0: 0 = every register cleared to 0; 1 = register i loaded with value i (debug preload).
- AW, $clog2(NREGS), address width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- rs_addr  in  NRD*AW  read addresses; port i = bits [i*AW +: AW].
- rs_data  out  NRD*XLEN  read data; port i = bits [i*XLEN +: XLEN].
- rs_pending  out  NRD  1 = register read on port i has an outstanding producer.
- reg_write  in  1  writeback enable.
- rd_addr  in  AW  writeback address.
- wb_data  in  XLEN  writeback data.
- issue_valid  in  1  an instruction with destination issue_rd is issued.
- issue_rd  in  AW  destination to mark pending.
- init_busy  out  1  1 while the reset sweep is running; ID must stall.

Behaviour:
- State machine (registered): INIT, READY. State is unknown at power-up; rst must be applied.
- INIT entry: at any posedge with rst=1: state<=INIT, init_ptr<=1, all pending bits<=0. This applies from either state, so a reset during the sweep restarts it from register 1.
- INIT sweep: at each posedge with rst=0, reg[init_ptr] <= init value (0, or init_ptr when INIT_MODE=1), then init_ptr++.
- INIT exit: the edge that writes reg[NREGS-1] also sets state<=READY. The sweep takes exactly NREGS-1 cycles after rst deasserts.
- init_busy = (state==INIT). Combinational from state, so init_busy=1 in the cycle after a reset edge.
- While INIT is active, reg_write and issue_valid are ignored.
- Reset values of outputs: init_busy=1; rs_data=0 on all ports; rs_pending=0 on all ports.
- Read ports: combinational, 0-cycle latency. rs_data[i] = 0 if any of the following holds:
  - rs_addr[i]==0;
  - rs_addr[i] ≥ NREGS;
  - state==INIT.
- Write-first bypass: in READY, if reg_write=1 and rd_addr==rs_addr[i]≠0, then rs_data[i]=wb_data in the same cycle.
- Otherwise rs_data[i] = reg[rs_addr[i]].
- Write: at posedge in READY, if reg_write=1, rd_addr≠0 and rd_addr<NREGS, then reg[rd_addr]<=wb_data.
  - Writes to address 0 or to addresses ≥ NREGS are dropped.
- Pending bits: one bit per register; pending[0] is always 0.
- Pending update at each posedge in READY:
  - reg_write clears pending[rd_addr];
  - issue_valid sets pending[issue_rd] (issue_rd≠0 and <NREGS).
  - If both target the same address on the same edge, the set wins (a new producer supersedes the completing one).
- rs_pending[i] = pending[rs_addr[i]] & ~(reg_write & rd_addr==rs_addr[i]).
  - Forced to 0 for address 0, addresses ≥ NREGS, and in INIT.
  - An issue in the current cycle does not affect rs_pending until the next cycle.
- Multiple read ports may use the same address; each gets identical data and pending flag.
- Pure flops for storage; no combinational loops.
- Synthesis: a single write port plus NRD read muxes; init_ptr is AW bits wide.

Test Plan:
- Reset sweep: hold rst for 2 cycles with INIT_MODE=1, NREGS=32 -> init_busy=1 for exactly 31 cycles after rst falls; afterwards rs_addr=5 gives rs_data=5, and rs_addr=0 gives 0.
- Reset mid-sweep: assert rst 10 cycles into the sweep -> init_busy stays 1 for a further 31 cycles after the release; all registers hold their init values at the end.
- Write/bypass: in READY, reg_write=1, rd_addr=7, wb_data=0xDEADBEEF, rs_addr port0=7 -> port0 shows 0xDEADBEEF in the same cycle and on the following cycles with reg_write=0.
- x0 protection: reg_write=1, rd_addr=0, wb_data=0x1234 -> every port reading addr 0 returns 0, both in that cycle and afterwards.
- Scoreboard: issue_valid with issue_rd=3 -> rs_pending=1 for reads of 3 from the next cycle. A later reg_write with rd_addr=3 -> rs_pending=0 in that same cycle.
- Simultaneous set/clear: issue_rd=3 and rd_addr=3 on the same edge -> pending[3]=1 after the edge; data written is still visible.
- Writes during INIT: reg_write=1, rd_addr=4, wb_data=0xFF during the sweep -> register 4 holds its init value after the sweep completes.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-read-port integer register file for ID.
// Register 0 reads as zero. A write-first bypass feeds every read port.
// A per-register pending bit tracks outstanding writebacks. After a
// synchronous reset, a sweep loads one register per cycle with its init value.
module reg_file_mp #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int NRD       = 2,
    parameter int INIT_MODE = 0,
    parameter int AW        = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_pending,
    input  logic                reg_write,
    input  logic [AW-1:0]       rd_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic                init_busy
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state_r;
    logic [AW-1:0]       init_ptr_r;
    logic [XLEN-1:0]     regs_r [NREGS];
    logic [NREGS-1:0]    pending_r;

    // An address is architecturally live only if it is non-zero and in range.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != {AW{1'b0}}) && (32'(a) < 32'(NREGS));
    endfunction

    // Value loaded into register p during the reset sweep.
    function automatic logic [XLEN-1:0] init_value(input logic [AW-1:0] p);
        logic [XLEN-1:0] v;
        if (INIT_MODE == 1) begin
            v = XLEN'(p);
        end else begin
            v = {XLEN{1'b0}};
        end
        return v;
    endfunction

    assign init_busy = (state_r == ST_INIT);

    // Sweep FSM, register writes and scoreboard updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_INIT;
            init_ptr_r <= AW'(1);
            pending_r  <= {NREGS{1'b0}};
        end else begin
            case (state_r)
                ST_INIT: begin
                    regs_r[init_ptr_r] <= init_value(init_ptr_r);
                    init_ptr_r         <= init_ptr_r + AW'(1);
                    if (init_ptr_r == AW'(NREGS - 1)) begin
                        state_r <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (reg_write && addr_ok(rd_addr)) begin
                        regs_r[rd_addr]    <= wb_data;
                        pending_r[rd_addr] <= 1'b0;
                    end
                    // Later assignment lets a new producer supersede the completing one.
                    if (issue_valid && addr_ok(issue_rd)) begin
                        pending_r[issue_rd] <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_INIT;
                    init_ptr_r <= AW'(1);
                    pending_r  <= {NREGS{1'b0}};
                end
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < NRD; g++) begin : g_rd
            logic [AW-1:0] addr_s;
            logic          hit_s;

            assign addr_s = rs_addr[g*AW +: AW];

            // Read mux with write-first bypass and pending-flag masking.
            always_comb begin
                rs_data[g*XLEN +: XLEN] = {XLEN{1'b0}};
                rs_pending[g]           = 1'b0;
                hit_s                   = 1'b0;
                if ((state_r == ST_READY) && addr_ok(addr_s)) begin
                    hit_s = reg_write && (rd_addr == addr_s);
                    if (hit_s) begin
                        rs_data[g*XLEN +: XLEN] = wb_data;
                    end else begin
                        rs_data[g*XLEN +: XLEN] = regs_r[addr_s];
                    end
                    rs_pending[g] = pending_r[addr_s] & ~hit_s;
                end else begin
                    rs_data[g*XLEN +: XLEN] = {XLEN{1'b0}};
                    rs_pending[g]           = 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp (NREGS=32, NRD=2, INIT_MODE=1).
module tb_reg_file_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic             clk;
    logic             rst;
    logic [2*AW-1:0]  rs_addr;
    logic [2*XLEN-1:0] rs_data;
    logic [1:0]       rs_pending;
    logic             reg_write;
    logic [AW-1:0]    rd_addr;
    logic [XLEN-1:0]  wb_data;
    logic             issue_valid;
    logic [AW-1:0]    issue_rd;
    logic             init_busy;

    int checks = 0;
    int errors = 0;

    reg_file_mp #(
        .XLEN(32), .NREGS(32), .NRD(2), .INIT_MODE(1)
    ) dut (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data),
        .rs_pending(rs_pending), .reg_write(reg_write), .rd_addr(rd_addr),
        .wb_data(wb_data), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .init_busy(init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   a0;
        logic [AW-1:0]   a1;
        logic            we;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] wb;
        logic            iv;
        logic [AW-1:0]   ird;
        logic [XLEN-1:0] d0;
        logic [XLEN-1:0] d1;
        logic            p0;
        logic            p1;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts init_busy cycles from now until it drops, bounded.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (init_busy && cnt < 100) begin
            cnt++;
            if (cnt == 20) begin
                chk("init_read_zero", rs_data[31:0], 32'h0);
            end
            tick();
        end
    endtask

    initial begin
        int cnt;
        rst = 1'b1; rs_addr = {5'd5, 5'd5}; reg_write = 1'b0; rd_addr = 5'd0;
        wb_data = 32'h0; issue_valid = 1'b0; issue_rd = 5'd0;

        // Reset for two cycles.
        tick();
        chk("rst_busy", 32'(init_busy), 32'h1);
        chk("rst_data0", rs_data[31:0], 32'h0);
        chk("rst_data1", rs_data[63:32], 32'h0);
        chk("rst_pend", 32'(rs_pending), 32'h0);
        tick();
        chk("rst_busy2", 32'(init_busy), 32'h1);

        // Sweep with writes/issues that must be ignored.
        rst = 1'b0;
        reg_write = 1'b1; rd_addr = 5'd4; wb_data = 32'h0000_00FF;
        issue_valid = 1'b1; issue_rd = 5'd6;
        count_busy(cnt);
        reg_write = 1'b0; issue_valid = 1'b0;
        chk("sweep_len", 32'(cnt), 32'd31);

        vecs[0]  = '{5'd5,  5'd0,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'd5,         32'd0,         1'b0, 1'b0};
        vecs[1]  = '{5'd4,  5'd6,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'd4,         32'd6,         1'b0, 1'b0};
        vecs[2]  = '{5'd7,  5'd7,  1'b1, 5'd7,  32'hDEADBEEF,  1'b0, 5'd0, 32'hDEADBEEF,  32'hDEADBEEF,  1'b0, 1'b0};
        vecs[3]  = '{5'd7,  5'd31, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'hDEADBEEF,  32'd31,        1'b0, 1'b0};
        vecs[4]  = '{5'd0,  5'd0,  1'b1, 5'd0,  32'h1234,      1'b0, 5'd0, 32'd0,         32'd0,         1'b0, 1'b0};
        vecs[5]  = '{5'd0,  5'd7,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'd0,         32'hDEADBEEF,  1'b0, 1'b0};
        vecs[6]  = '{5'd3,  5'd3,  1'b0, 5'd0,  32'h0,         1'b1, 5'd3, 32'd3,         32'd3,         1'b0, 1'b0};
        vecs[7]  = '{5'd3,  5'd2,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'd3,         32'd2,         1'b1, 1'b0};
        vecs[8]  = '{5'd3,  5'd3,  1'b1, 5'd3,  32'hA5A50003,  1'b0, 5'd0, 32'hA5A50003,  32'hA5A50003,  1'b0, 1'b0};
        vecs[9]  = '{5'd3,  5'd3,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'hA5A50003,  32'hA5A50003,  1'b0, 1'b0};
        vecs[10] = '{5'd3,  5'd3,  1'b0, 5'd0,  32'h0,         1'b1, 5'd3, 32'hA5A50003,  32'hA5A50003,  1'b0, 1'b0};
        vecs[11] = '{5'd3,  5'd1,  1'b1, 5'd3,  32'h3333,      1'b1, 5'd3, 32'h3333,      32'd1,         1'b0, 1'b0};
        vecs[12] = '{5'd3,  5'd1,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'h3333,      32'd1,         1'b1, 1'b0};
        vecs[13] = '{5'd31, 5'd30, 1'b1, 5'd31, 32'hCAFE,      1'b0, 5'd0, 32'hCAFE,      32'd30,        1'b0, 1'b0};
        vecs[14] = '{5'd31, 5'd3,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'hCAFE,      32'h3333,      1'b0, 1'b1};
        vecs[15] = '{5'd3,  5'd3,  1'b1, 5'd3,  32'h44,        1'b0, 5'd0, 32'h44,        32'h44,        1'b0, 1'b0};
        vecs[16] = '{5'd3,  5'd3,  1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'h44,        32'h44,        1'b0, 1'b0};

        for (int i = 0; i < 17; i++) begin
            rs_addr = {vecs[i].a1, vecs[i].a0};
            reg_write = vecs[i].we; rd_addr = vecs[i].rd; wb_data = vecs[i].wb;
            issue_valid = vecs[i].iv; issue_rd = vecs[i].ird;
            #3;
            chk($sformatf("v%0d_d0", i), rs_data[31:0], vecs[i].d0);
            chk($sformatf("v%0d_d1", i), rs_data[63:32], vecs[i].d1);
            chk($sformatf("v%0d_p0", i), 32'(rs_pending[0]), 32'(vecs[i].p0));
            chk($sformatf("v%0d_p1", i), 32'(rs_pending[1]), 32'(vecs[i].p1));
            tick();
        end
        reg_write = 1'b0; issue_valid = 1'b0;

        // Leave register 5 pending, then reset mid-sweep.
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick();
        issue_valid = 1'b0;
        rs_addr = {5'd5, 5'd5};
        #3;
        chk("pend5_set", 32'(rs_pending), 32'h3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("mid_busy", 32'(init_busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy(cnt);
        chk("resweep_len", 32'(cnt), 32'd31);

        // Every register back at its init value, no pending bits.
        for (int r = 0; r < 32; r++) begin
            rs_addr = {5'(31 - r), 5'(r)};
            #1;
            chk($sformatf("init_r%0d", r), rs_data[31:0], 32'(r));
            chk($sformatf("init_r%0d_p1", 31 - r), rs_data[63:32], 32'(31 - r));
            chk($sformatf("init_pend%0d", r), 32'(rs_pending), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
